cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder; successor to the fixed 46-bit combinational CLA in the dadda multiplier.
//  Splits the WIDTH-bit add into STAGES carry-lookahead segments, one segment resolved per pipeline stage.
//  Adds carry-in, carry-out and a valid/ready stream handshake, so the adder can sit between the multiplier tree and normalise/round.
// PARAMETERS
//  WIDTH   46  operand/sum width in bits (>=2)
//  STAGES  2   pipeline stages = latency in cycles (1..WIDTH); segment width SEG=ceil(WIDTH/STAGES)
//  GROUP   4   lookahead group size inside a segment (G/P computed per group, group carries by lookahead)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      adder can accept operands this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  (A + B + cin) mod 2^WIDTH
//  out_cout   out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits, out_valid, out_sum, out_cout = 0; in flight data discarded.
//  - Segment s (0..STAGES-1) = bits [s*SEG +: SEG]; top segment width WIDTH-(STAGES-1)*SEG, elaboration error if <1.
//  - Stage s adds segment s of the delayed operands with the carry registered by stage s-1 (stage 0 uses in_cin).
//    Lower finished sum bits skew forward; unconsumed upper operand bits are delayed alongside.
//  - Transfer: input accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready.
//  - Stall: adv = !out_valid || out_ready. When adv=0, every stage holds (data and valid). in_ready = adv (combinational).
//  - Latency: exactly STAGES cycles from accept to out_valid with no stall; throughput 1 result/cycle.
//  - Bubbles: an empty stage still advances and carries valid=0. out_sum/out_cout hold their last value while out_valid=0.
//  - out_valid&&!out_ready: out_sum/out_cout stable until consumed.
//  - Simultaneous accept and consume in the same cycle is legal at full occupancy.
//  - Wrap-around: sum modulo 2^WIDTH; the carry out of the top segment goes to out_cout, never to sum bits.
//  - STAGES=1: single-segment CLA with its result registered; latency 1.
//  - Reset mid-operation: all results in flight are lost; the first accept after release has normal latency.
// CONFIGURATION
//  CLA_ADDER_PIPE_SUB_EN defined: extra port in_sub (in, 1) sampled with the operands.
//    in_sub=1: B is inverted and the effective cin = 1 (in_cin ignored) -> out_sum = A - B mod 2^WIDTH.
//    out_cout = 1 means no borrow (A >= B unsigned).
//    in_sub=0: identical to the undefined case.
//  Undefined: no in_sub port; pure add with in_cin.
// TESTING (WIDTH=46, STAGES=2 unless noted)
//  1. A=46'h3FFF_FFFF_FFFF, B=1, cin=0, out_ready=1 -> out_sum=0, out_cout=1, out_valid exactly 2 cycles after accept.
//  2. Back-to-back accepts (1+2, 3+4, 5+6) on 3 consecutive cycles -> sums 3, 7, 11 on 3 consecutive cycles; in_ready stays 1.
//  3. out_ready=0 with the pipe full -> in_ready=0, out_sum held and no loss. Release -> remaining results in order, one per cycle.
//  4. rst_n low mid-stream with 2 ops in flight -> out_valid=0, out_sum=0 asynchronously; no stale result after release.
//  5. WIDTH=8, STAGES=3 (SEG=3, top=2): A=8'hFF, B=8'h01, cin=1 -> out_sum=8'h01, out_cout=1, latency 3; also random sweep against a reference model.
//  6. SUB_EN: A=5, B=7, in_sub=1 -> out_sum=46'h3FFF_FFFF_FFFE, out_cout=0; A=7, B=5 -> out_sum=2, out_cout=1.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder: WIDTH bits split into STAGES segments, one segment resolved per stage,
// with valid/ready handshake. Define CLA_ADDER_PIPE_SUB_EN to add the in_sub (A - B) port.

module cla_seg #(
  parameter int W     = 4,
  parameter int GROUP = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = (W + GROUP - 1) / GROUP;

  logic [W-1:0]  p, g, c;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;
  logic          acc, pp;

  assign p = a ^ b;
  assign g = a & b;

  // group generate/propagate; the last group may be partial
  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        if (k * GROUP + j < W) begin
          gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
          gp[k] = gp[k] & p[k*GROUP+j];
        end
      end
    end
  end

  // every group carry is a flat sum of products over all lower groups and cin
  always_comb begin
    gc    = '0;
    acc   = 1'b0;
    pp    = 1'b0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      acc = gg[k];
      pp  = gp[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pp & gg[j]);
        pp  = pp & gp[j];
      end
      gc[k+1] = acc | (pp & cin);
    end
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < W; i++)
      if (i % GROUP == 0) c[i] = gc[i/GROUP];
    for (int i = 1; i < W; i++)
      if (i % GROUP != 0) c[i] = g[i-1] | (p[i-1] & c[i-1]);
  end

  assign sum  = p ^ c;
  assign cout = gc[NG];
endmodule

module cla_adder_pipe #(
  parameter int WIDTH  = 46,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_ADDER_PIPE_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);
  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;
  localparam int TOP = WIDTH - (STAGES - 1) * SEG;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || GROUP < 1 || TOP < 1) begin : g_bad_cfg
    $error("cla_adder_pipe: illegal WIDTH/STAGES/GROUP combination");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

`ifdef CLA_ADDER_PIPE_SUB_EN
  // subtract as A + ~B + 1; carry out then means "no borrow"
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c_eff = in_sub | in_cin;
`else
  assign b_eff = in_b;
  assign c_eff = in_cin;
`endif

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_sum   = s_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * SEG;
    localparam int SW = (s == STAGES - 1) ? TOP : SEG;

    logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
    logic             c_i, v_i;
    logic [SW-1:0]    seg_sum;
    logic             seg_cout;

    if (s == 0) begin : g_head
      assign a_i = in_a;
      assign b_i = b_eff;
      assign s_i = '0;
      assign c_i = c_eff;
      assign v_i = in_valid;
    end else begin : g_body
      assign a_i = a_q[s-1];
      assign b_i = b_q[s-1];
      assign s_i = s_q[s-1];
      assign c_i = c_q[s-1];
      assign v_i = vld_pipe[s];
    end

    cla_seg #(.W(SW), .GROUP(GROUP)) u_seg (
      .a    (a_i[LO +: SW]),
      .b    (b_i[LO +: SW]),
      .cin  (c_i),
      .sum  (seg_sum),
      .cout (seg_cout)
    );

    always_comb begin
      s_n           = s_i;
      s_n[LO +: SW] = seg_sum;
    end

    // data only loads with a valid op, so bubbles leave the last result on the outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
        c_q[s] <= 1'b0;
      end else if (adv && v_i) begin
        a_q[s] <= a_i;
        b_q[s] <= b_i;
        s_q[s] <= s_n;
        c_q[s] <= seg_cout;
      end
    end
  end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: 46-bit/2-stage and 8-bit/3-stage instances.
module tb_cla_adder_pipe;
  localparam int W  = 46;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic          v8, r8, cin8, sub8, ov8, ordy8, co8;
  logic [W8-1:0] a8, b8, s8;

  int tests = 0;
  int fails = 0;
  logic [W:0]  exp_q[$];
  logic [W8:0] exp8_q[$];

  cla_adder_pipe #(.WIDTH(W), .STAGES(2), .GROUP(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CLA_ADDER_PIPE_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
  );

  cla_adder_pipe #(.WIDTH(W8), .STAGES(3), .GROUP(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_cin(cin8),
`ifdef CLA_ADDER_PIPE_SUB_EN
    .in_sub(sub8),
`endif
    .out_valid(ov8), .out_ready(ordy8), .out_sum(s8), .out_cout(co8)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
`ifdef CLA_ADDER_PIPE_SUB_EN
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin) + (W+1)'(sub & 1'b0);
  endfunction

  function automatic logic [W8:0] model8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + (W8+1)'(cin);
  endfunction

  // one clock: record handshakes against the scoreboard, then advance
  task automatic step(output bit acc, output bit took, output logic [W:0] got, output logic [W:0] exp);
    #1;
    acc  = in_valid && in_ready;
    took = out_valid && out_ready;
    got  = {out_cout, out_sum};
    exp  = 'x;
    if (took && exp_q.size() > 0) exp = exp_q.pop_front();
    if (acc) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
    @(posedge clk); #1;
  endtask

  task automatic step8(output bit acc, output bit took, output logic [W8:0] got, output logic [W8:0] exp);
    #1;
    acc  = v8 && r8;
    took = ov8 && ordy8;
    got  = {co8, s8};
    exp  = 'x;
    if (took && exp8_q.size() > 0) exp = exp8_q.pop_front();
    if (acc) exp8_q.push_back(model8(a8, b8, cin8));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (out_sum !== '0) begin fails++; $display("FAIL reset_sum got=%h exp=0", out_sum); end
    tests++; if (out_cout !== 1'b0) begin fails++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    tests++; if (ov8 !== 1'b0 || s8 !== '0) begin fails++; $display("FAIL reset_w8 got=%b/%h exp=0/0", ov8, s8); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bit acc, took; logic [W:0] got, exp; int lat;
    in_a = '1; in_b = W'(1); in_cin = 1'b0; in_valid = 1'b1;
    step(acc, took, got, exp);
    tests++; if (!acc) begin fails++; $display("FAIL wrap_accept got=0 exp=1"); end
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      step(acc, took, got, exp);
      if (took) begin
        lat = c;
        tests++; if (got !== exp) begin fails++; $display("FAIL wrap_sb got=%h exp=%h", got, exp); end
        tests++; if (got !== {1'b1, {W{1'b0}}}) begin fails++; $display("FAIL wrap_value got=%h exp=%h", got, {1'b1, {W{1'b0}}}); end
      end
    end
    tests++; if (lat != 2) begin fails++; $display("FAIL wrap_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_back_to_back();
    bit acc, took; logic [W:0] got, exp; int n;
    logic [W:0] want [3];
    want[0] = (W+1)'(3); want[1] = (W+1)'(7); want[2] = (W+1)'(11);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 3);
      in_a = W'(2*c + 1); in_b = W'(2*c + 2); in_cin = 1'b0;
      step(acc, took, got, exp);
      if (c < 3) begin
        tests++; if (!acc) begin fails++; $display("FAIL b2b_ready cycle=%0d got=0 exp=1", c); end
      end
      if (took) begin
        tests++; if (got !== exp) begin fails++; $display("FAIL b2b_sb got=%h exp=%h", got, exp); end
        if (n < 3) begin
          tests++; if (got !== want[n]) begin fails++; $display("FAIL b2b_value got=%h exp=%h", got, want[n]); end
          tests++; if (c != 2 + n) begin fails++; $display("FAIL b2b_cycle got=%0d exp=%0d", c, 2 + n); end
        end
        n++;
      end
    end
    in_valid = 1'b0;
    tests++; if (n != 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", n); end
  endtask

  task automatic test_stall();
    bit acc, took; logic [W:0] got, exp; int idx, n;
    logic [W-1:0] oa [3]; logic [W-1:0] ob [3]; logic oc [3]; logic [W:0] want [3];
    oa[0] = W'(100); ob[0] = W'(200); oc[0] = 1'b0; want[0] = (W+1)'(300);
    oa[1] = W'(7);   ob[1] = W'(8);   oc[1] = 1'b1; want[1] = (W+1)'(16);
    oa[2] = '1;      ob[2] = W'(2);   oc[2] = 1'b0; want[2] = {1'b1, W'(1)};
    idx = 0; n = 0;
    for (int c = 0; c < 15; c++) begin
      in_valid  = (idx < 3);
      in_a = oa[idx % 3]; in_b = ob[idx % 3]; in_cin = oc[idx % 3];
      out_ready = (c >= 5);
      #1;
      if (c >= 2 && c < 5) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, in_ready); end
        tests++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== want[0]) begin
          fails++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/%h", c, out_valid, {out_cout, out_sum}, want[0]);
        end
      end
      step(acc, took, got, exp);
      if (acc) idx++;
      if (took) begin
        tests++; if (got !== exp) begin fails++; $display("FAIL stall_sb got=%h exp=%h", got, exp); end
        if (n < 3) begin
          tests++; if (got !== want[n] || c != 5 + n) begin
            fails++; $display("FAIL stall_drain got=%h@%0d exp=%h@%0d", got, c, want[n], 5 + n);
          end
        end
        n++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests++; if (n != 3 || idx != 3) begin fails++; $display("FAIL stall_count got=%0d/%0d exp=3/3", n, idx); end
  endtask

  task automatic test_reset_mid();
    bit acc, took; logic [W:0] got, exp; int lat;
    in_valid = 1'b1; in_a = W'(11); in_b = W'(22); in_cin = 1'b0;
    step(acc, took, got, exp);
    in_a = W'(33); in_b = W'(44);
    step(acc, took, got, exp);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0) begin
      fails++; $display("FAIL rstmid_clear got=%b/%h/%b exp=0/0/0", out_valid, out_sum, out_cout);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(acc, took, got, exp);
      tests++; if (took) begin fails++; $display("FAIL rstmid_stale got=%h exp=none", got); end
    end
    in_valid = 1'b1; in_a = W'(9); in_b = W'(9); in_cin = 1'b1;
    step(acc, took, got, exp);
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      step(acc, took, got, exp);
      if (took) begin
        lat = c;
        tests++; if (got !== (W+1)'(19) || got !== exp) begin fails++; $display("FAIL rstmid_value got=%h exp=13", got); end
      end
    end
    tests++; if (lat != 2) begin fails++; $display("FAIL rstmid_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_w8();
    bit acc, took; logic [W8:0] got, exp; int lat, issued, seen;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; ordy8 = 1'b1;
    step8(acc, took, got, exp);
    v8 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      step8(acc, took, got, exp);
      if (took) begin
        lat = c;
        tests++; if (got !== 9'h101) begin fails++; $display("FAIL w8_value got=%h exp=101", got); end
      end
    end
    tests++; if (lat != 3) begin fails++; $display("FAIL w8_latency got=%0d exp=3", lat); end
    issued = 0; seen = 0;
    for (int c = 0; c < 400 && (issued < 40 || seen < 40); c++) begin
      v8    = (issued < 40) && ($urandom_range(0, 3) != 0);
      a8    = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      ordy8 = ($urandom_range(0, 3) != 0);
      step8(acc, took, got, exp);
      if (acc) issued++;
      if (took) begin
        seen++;
        tests++; if (got !== exp) begin fails++; $display("FAIL w8_random got=%h exp=%h", got, exp); end
      end
    end
    v8 = 1'b0; ordy8 = 1'b1;
    tests++; if (seen != 40) begin fails++; $display("FAIL w8_count got=%0d exp=40", seen); end
  endtask

`ifdef CLA_ADDER_PIPE_SUB_EN
  task automatic test_sub();
    bit acc, took; logic [W:0] got, exp; int n;
    logic [W:0] want [2];
    want[0] = {1'b0, 46'h3FFF_FFFF_FFFE}; want[1] = {1'b1, W'(2)};
    n = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 2); in_sub = 1'b1; in_cin = 1'b0;
      in_a = (c == 0) ? W'(5) : W'(7); in_b = (c == 0) ? W'(7) : W'(5);
      step(acc, took, got, exp);
      if (took) begin
        tests++; if (got !== exp || (n < 2 && got !== want[n])) begin
          fails++; $display("FAIL sub_value got=%h exp=%h", got, want[n % 2]);
        end
        n++;
      end
    end
    in_valid = 1'b0; in_sub = 1'b0;
    tests++; if (n != 2) begin fails++; $display("FAIL sub_count got=%0d exp=2", n); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; ordy8 = 1'b1;
    test_reset();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_w8();
`ifdef CLA_ADDER_PIPE_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
